iq_integrate_dump: RTL and testbench

//  Integrate-and-dump stage of the IQ demodulator, directly downstream of the sample front end.

---
 rtl/iq_demod_pkg.sv | 21 ++
 rtl/iq_integrate_dump_if.sv | 31 +++
 rtl/ADD_LOOKAHEAD.sv | 23 ++
 rtl/iq_sat_acc.sv | 36 +++
 rtl/iq_integrate_dump.sv | 98 +++++++++
 tb/tb_iq_integrate_dump.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/iq_demod_pkg.sv
// rtl/iq_demod_pkg.sv - shared defaults and saturation limits for the IQ demodulator
// Purpose: default widths/window length and the two's-complement clamp limits
//          used by the integrate-and-dump stage.
// Ports:   none (package)
package iq_demod_pkg;

   localparam int IQ_IN_W      = 8;
   localparam int IQ_ACC_W     = 12;
   localparam int IQ_N_SAMPLES = 4;

   // Largest positive value of a w-bit signed number.
   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Most negative value of a w-bit signed number.
   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/iq_integrate_dump_if.sv
// rtl/iq_integrate_dump_if.sv - sample-in / window-sum-out bundle of the integrate-and-dump stage
// Purpose: groups the input sample stream, the output valid/ready stream and the
//          status/control lines of iq_integrate_dump.
// Signals: clear, in_valid, i_in, q_in, out_ready (towards the stage);
//          out_valid, i_out, q_out, overrun, sat (from the stage).
// Modports: slave = the stage itself, master = the surrounding logic.
interface iq_integrate_dump_if #(
   parameter int IN_W  = 8,
   parameter int ACC_W = 12
);
   logic                    clear;
   logic                    in_valid;
   logic signed [IN_W-1:0]  i_in;
   logic signed [IN_W-1:0]  q_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] i_out;
   logic signed [ACC_W-1:0] q_out;
   logic                    overrun;
   logic                    sat;

   modport slave (
      input  clear, in_valid, i_in, q_in, out_ready,
      output out_valid, i_out, q_out, overrun, sat
   );

   modport master (
      output clear, in_valid, i_in, q_in, out_ready,
      input  out_valid, i_out, q_out, overrun, sat
   );
endinterface

// File: rtl/ADD_LOOKAHEAD.sv
// rtl/ADD_LOOKAHEAD.sv - generate/propagate carry adder, modulo 2^WIDTH
// Purpose: WIDTH-bit adder built from per-bit generate/propagate terms; the carry
//          out of the top bit is discarded (wrapping sum).
// Ports:   a, b (in, WIDTH) operands; sum (out, WIDTH) a+b mod 2^WIDTH.
module ADD_LOOKAHEAD #(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;

   always_comb begin
      p    = a ^ b;
      c    = '0;
      for (int k = 1; k < WIDTH; k++) begin
         c[k] = (a[k-1] & b[k-1]) | (p[k-1] & c[k-1]);
      end
      sum  = p ^ c;
   end
endmodule

// File: rtl/iq_sat_acc.sv
// rtl/iq_sat_acc.sv - saturating signed add for one accumulator rail
// Purpose: a + b through ADD_LOOKAHEAD, clamped to the ACC_W signed range.
//          Purely combinational.
// Ports:   a, b (in, ACC_W signed) operands; sum (out, ACC_W signed) clamped result;
//          sat_hit (out, 1) the clamp was applied.
module iq_sat_acc
   import iq_demod_pkg::*;
#(
   parameter int ACC_W = IQ_ACC_W
) (
   input  logic signed [ACC_W-1:0] a,
   input  logic signed [ACC_W-1:0] b,
   output logic signed [ACC_W-1:0] sum,
   output logic                    sat_hit
);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

   logic [ACC_W-1:0] raw;

   ADD_LOOKAHEAD #(.WIDTH(ACC_W)) u_add (
      .a   (a),
      .b   (b),
      .sum (raw)
   );

   // Overflow only possible when both operands share a sign; the direction of
   // the clamp follows that shared sign.
   always_comb begin
      sat_hit = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
      sum     = signed'(raw);
      if (sat_hit) begin
         sum = a[ACC_W-1] ? MIN_V : MAX_V;
      end
   end
endmodule

// File: rtl/iq_integrate_dump.sv
// rtl/iq_integrate_dump.sv - I/Q integrate-and-dump over N_SAMPLES valid samples
// Purpose: sums one chip period of I and Q samples per rail with saturation and
//          presents each window sum on a valid/ready output.
// Ports:   clk (in) clock; nrst (in) async active-low reset;
//          bus (slave) clear, in_valid, i_in, q_in, out_ready in;
//                      out_valid, i_out, q_out, overrun, sat out.
module iq_integrate_dump
   import iq_demod_pkg::*;
#(
   parameter int IN_W      = IQ_IN_W,
   parameter int ACC_W     = IQ_ACC_W,
   parameter int N_SAMPLES = IQ_N_SAMPLES
) (
   input  logic                clk,
   input  logic                nrst,
   iq_integrate_dump_if.slave  bus
);
   localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

   generate
      if (ACC_W < IN_W) begin : g_bad_acc_w
         $error("iq_integrate_dump: ACC_W must be >= IN_W");
      end
      if (N_SAMPLES < 1) begin : g_bad_n
         $error("iq_integrate_dump: N_SAMPLES must be >= 1");
      end
   endgenerate

   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc_i, acc_q;
   logic signed [ACC_W-1:0] ext_i, ext_q;
   logic signed [ACC_W-1:0] sum_i, sum_q;
   logic signed [ACC_W-1:0] nxt_i, nxt_q;
   logic signed [ACC_W-1:0] i_out_r, q_out_r;
   logic                    hit_i, hit_q;
   logic                    out_valid_r, overrun_r, sat_r;
   logic                    first, last, dump, clamp;

   assign ext_i = ACC_W'(signed'(bus.i_in));
   assign ext_q = ACC_W'(signed'(bus.q_in));

   iq_sat_acc #(.ACC_W(ACC_W)) u_acc_i (.a(acc_i), .b(ext_i), .sum(sum_i), .sat_hit(hit_i));
   iq_sat_acc #(.ACC_W(ACC_W)) u_acc_q (.a(acc_q), .b(ext_q), .sum(sum_q), .sat_hit(hit_q));

   // The first sample of a window loads rather than adds, so a stale
   // accumulator can never clamp or leak into the new window.
   assign first = (cnt == '0);
   assign last  = (cnt == CNT_LAST);
   assign nxt_i = first ? ext_i : sum_i;
   assign nxt_q = first ? ext_q : sum_q;
   assign dump  = bus.in_valid & last;
   assign clamp = bus.in_valid & ~first & (hit_i | hit_q);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt         <= '0;
         acc_i       <= '0;
         acc_q       <= '0;
         i_out_r     <= '0;
         q_out_r     <= '0;
         out_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
         sat_r       <= 1'b0;
      end else if (bus.clear) begin
         // Output data is left as is; only its valid qualifier is dropped.
         cnt         <= '0;
         acc_i       <= '0;
         acc_q       <= '0;
         out_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
         sat_r       <= 1'b0;
      end else begin
         overrun_r <= dump & out_valid_r & ~bus.out_ready;
         if (bus.in_valid) begin
            acc_i <= nxt_i;
            acc_q <= nxt_q;
            cnt   <= last ? '0 : cnt + CNT_W'(1);
         end
         if (clamp) begin
            sat_r <= 1'b1;
         end
         if (dump) begin
            i_out_r     <= nxt_i;
            q_out_r     <= nxt_q;
            out_valid_r <= 1'b1;
         end else if (out_valid_r & bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.i_out     = i_out_r;
   assign bus.q_out     = q_out_r;
   assign bus.overrun   = overrun_r;
   assign bus.sat       = sat_r;
endmodule

// File: tb/tb_iq_integrate_dump.sv
// tb/tb_iq_integrate_dump.sv - directed self-checking bench for iq_integrate_dump
module tb_iq_integrate_dump;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   dumps;

   always #5 clk = ~clk;

   iq_integrate_dump_if #(.IN_W(8), .ACC_W(12)) bus12 ();
   iq_integrate_dump_if #(.IN_W(8), .ACC_W(9))  bus9 ();
   iq_integrate_dump_if #(.IN_W(8), .ACC_W(12)) bus1 ();

   iq_integrate_dump #(.IN_W(8), .ACC_W(12), .N_SAMPLES(4)) dut12 (.clk(clk), .nrst(nrst), .bus(bus12));
   iq_integrate_dump #(.IN_W(8), .ACC_W(9),  .N_SAMPLES(4)) dut9  (.clk(clk), .nrst(nrst), .bus(bus9));
   iq_integrate_dump #(.IN_W(8), .ACC_W(12), .N_SAMPLES(1)) dut1  (.clk(clk), .nrst(nrst), .bus(bus1));

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send12(input int i, input int q);
      bus12.in_valid = 1'b1;
      bus12.i_in     = 8'(i);
      bus12.q_in     = 8'(q);
      tick();
      bus12.in_valid = 1'b0;
   endtask

   task automatic send9(input int i, input int q);
      bus9.in_valid = 1'b1;
      bus9.i_in     = 8'(i);
      bus9.q_in     = 8'(q);
      tick();
      bus9.in_valid = 1'b0;
   endtask

   task automatic send1(input int i, input int q);
      bus1.in_valid = 1'b1;
      bus1.i_in     = 8'(i);
      bus1.q_in     = 8'(q);
      tick();
      bus1.in_valid = 1'b0;
   endtask

   initial begin
      int vi[4];
      int vq[4];
      vi = '{10, 20, 30, 40};
      vq = '{-1, -2, -3, -4};

      bus12.clear = 0; bus12.in_valid = 0; bus12.i_in = 0; bus12.q_in = 0; bus12.out_ready = 1;
      bus9.clear  = 0; bus9.in_valid  = 0; bus9.i_in  = 0; bus9.q_in  = 0; bus9.out_ready  = 1;
      bus1.clear  = 0; bus1.in_valid  = 0; bus1.i_in  = 0; bus1.q_in  = 0; bus1.out_ready  = 1;

      // reset state
      tick();
      check("rst_out_valid", bus12.out_valid, 0);
      check("rst_i_out", bus12.i_out, 0);
      check("rst_q_out", bus12.q_out, 0);
      check("rst_overrun", bus12.overrun, 0);
      check("rst_sat", bus12.sat, 0);
      nrst = 1'b1;

      // 1: reset mid-window discards the partial sum
      send12(7, 7);
      send12(7, 7);
      nrst = 1'b0;
      #1;
      check("midrst_out_valid", bus12.out_valid, 0);
      check("midrst_i_out", bus12.i_out, 0);
      tick();
      nrst = 1'b1;
      for (int k = 0; k < 3; k++) send12(1, 0);
      check("t1_no_early_dump", bus12.out_valid, 0);
      send12(1, 0);
      check("t1_out_valid", bus12.out_valid, 1);
      check("t1_i_out", bus12.i_out, 4);
      tick();
      check("t1_drop_valid", bus12.out_valid, 0);

      // 2: back-to-back window, consumer always ready
      for (int k = 0; k < 4; k++) send12(vi[k], vq[k]);
      check("t2_out_valid", bus12.out_valid, 1);
      check("t2_i_out", bus12.i_out, 100);
      check("t2_q_out", bus12.q_out, -10);
      tick();
      check("t2_valid_low", bus12.out_valid, 0);
      check("t2_i_hold", bus12.i_out, 100);

      // 3: same samples with idle gaps of 1..3 cycles
      dumps = 0;
      for (int k = 0; k < 4; k++) begin
         send12(vi[k] + 1, vq[k] - 1);
         dumps += int'(bus12.out_valid);
         if (k == 3) begin
            check("t3_i_out", bus12.i_out, 104);
            check("t3_q_out", bus12.q_out, -14);
         end
         for (int g = 0; g < k + 1; g++) begin
            tick();
            dumps += int'(bus12.out_valid);
         end
      end
      check("t3_one_dump", dumps, 1);

      // 4: saturation on a 9-bit accumulator
      send9(127, 0);
      send9(127, 0);
      check("t4_no_sat_yet", bus9.sat, 0);
      send9(127, 0);
      send9(127, 0);
      check("t4_i_clamp", bus9.i_out, 255);
      check("t4_sat_set", bus9.sat, 1);
      for (int k = 0; k < 4; k++) send9(0, -128);
      check("t4_q_clamp", bus9.q_out, -256);
      check("t4_sat_sticky", bus9.sat, 1);
      bus9.clear = 1'b1;
      tick();
      bus9.clear = 1'b0;
      check("t4_sat_cleared", bus9.sat, 0);
      check("t4_valid_cleared", bus9.out_valid, 0);

      // 5: consumer stalled across two windows
      bus12.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send12(1, 0);
      check("t5_first_valid", bus12.out_valid, 1);
      check("t5_first_i", bus12.i_out, 4);
      check("t5_no_overrun", bus12.overrun, 0);
      for (int k = 0; k < 3; k++) send12(2, 0);
      check("t5_data_stable", bus12.i_out, 4);
      send12(2, 0);
      check("t5_overrun", bus12.overrun, 1);
      check("t5_i_overwrite", bus12.i_out, 8);
      check("t5_still_valid", bus12.out_valid, 1);
      tick();
      check("t5_overrun_pulse", bus12.overrun, 0);
      check("t5_valid_held", bus12.out_valid, 1);
      bus12.out_ready = 1'b1;
      tick();
      check("t5_valid_taken", bus12.out_valid, 0);

      // 6: clear mid-window and in the dump cycle
      send12(9, 0);
      send12(9, 0);
      bus12.clear = 1'b1; bus12.in_valid = 1'b1; bus12.i_in = 8'd50;
      tick();
      bus12.clear = 1'b0; bus12.in_valid = 1'b0;
      check("t6_clear_valid", bus12.out_valid, 0);
      for (int k = 0; k < 4; k++) send12(5, 0);
      check("t6_i_out", bus12.i_out, 20);
      tick();
      for (int k = 0; k < 3; k++) send12(5, 0);
      bus12.clear = 1'b1; bus12.in_valid = 1'b1; bus12.i_in = 8'd5;
      tick();
      bus12.clear = 1'b0; bus12.in_valid = 1'b0;
      check("t6_dump_cleared", bus12.out_valid, 0);
      check("t6_i_kept", bus12.i_out, 20);
      for (int k = 0; k < 3; k++) send12(3, 0);
      check("t6_cnt_restart", bus12.out_valid, 0);
      send12(3, 0);
      check("t6_redump_valid", bus12.out_valid, 1);
      check("t6_redump_i", bus12.i_out, 12);

      // N_SAMPLES=1: every valid sample is dumped unchanged
      send1(-5, 6);
      check("n1_valid", bus1.out_valid, 1);
      check("n1_i", bus1.i_out, -5);
      check("n1_q", bus1.q_out, 6);
      send1(100, -128);
      check("n1_b2b_i", bus1.i_out, 100);
      check("n1_b2b_q", bus1.q_out, -128);
      check("n1_b2b_overrun", bus1.overrun, 0);
      tick();
      check("n1_valid_low", bus1.out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
